conv1d_seq_ctrl: RTL and testbench

Sequencing controller for the conv1d accelerator datapath. On a `start` request it loads the kernel weights into the weight registers, then walks every valid output position. For each position it issues input-memory reads and drives the accumulator clear/enable and output-memory write strobes. It owns no arithmetic: the MAC, weight registers and memories sit outside and are steered by this block's control outputs.

---
 rtl/conv1d_pkg.sv | 24 ++
 rtl/conv1d_seq_ctrl_delay.sv | 29 ++
 rtl/conv1d_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_conv1d_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared types and width helpers for the conv1d accelerator control and datapath.
package conv1d_pkg;

  localparam int KMAX_DEF = 8;
  localparam int NMAX_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit so a kernel of exactly KMAX taps is representable.
  function automatic int ksize_width(input int k);
    return $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/conv1d_seq_ctrl_delay.sv
// Registered delay line used to align control strobes with the memory read latency.
module ctrl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/conv1d_seq_ctrl.sv
// Sequencer for the conv1d datapath: loads kernel weights, then walks every
// output position issuing input reads plus accumulator and write strobes.
module conv1d_seq_ctrl
  import conv1d_pkg::*;
#(
  parameter int KMAX = KMAX_DEF,
  parameter int NMAX = NMAX_DEF,
  parameter int AW   = addr_width(NMAX),
  parameter int KW   = ksize_width(KMAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     len,
  input  logic [KW-1:0]   ksize,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   w_raddr,
  output logic [KMAX-1:0] w_ld,
  output logic [AW-1:0]   mem_raddr,
  output logic            acc_clr,
  output logic            acc_en,
  output logic [KW-1:0]   k_idx,
  output logic            out_we,
  output logic [AW-1:0]   out_waddr
);

  seq_state_t state, state_next;

  logic [AW:0]   j_reg, j_next, len_reg, len_next;
  logic [KW-1:0] k_reg, k_next, ksize_reg, ksize_next;
  logic          err_reg, err_next;
  logic          busy_reg, done_reg;
  logic [AW-1:0] w_raddr_reg, mem_raddr_reg;
  logic [AW-1:0] tap_addr;
  logic          cfg_ok, k_last, j_last;

  assign cfg_ok = (ksize != '0) && (ksize <= KW'(KMAX)) &&
                  ((AW+1)'(ksize) <= len) && (len <= (AW+1)'(NMAX));
  assign k_last = (k_reg == ksize_reg - KW'(1));
  // Last output index is len - ksize, i.e. M - 1.
  assign j_last = (j_reg == len_reg - (AW+1)'(ksize_reg));

  always_comb begin
    state_next = state;
    j_next     = j_reg;
    k_next     = k_reg;
    len_next   = len_reg;
    ksize_next = ksize_reg;
    err_next   = err_reg;
    case (state)
      S_IDLE: begin
        if (start) begin
          err_next   = !cfg_ok;
          len_next   = len;
          ksize_next = ksize;
          j_next     = '0;
          k_next     = '0;
          state_next = cfg_ok ? S_LOAD_W : S_DONE;
        end
      end
      S_LOAD_W: begin
        if (k_last) begin
          k_next     = '0;
          j_next     = '0;
          state_next = S_RUN;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      S_RUN: begin
        if (k_last) begin
          k_next = '0;
          if (j_last) begin
            state_next = S_DRAIN;
          end else begin
            j_next = j_reg + (AW+1)'(1);
          end
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      S_DRAIN: begin
        // k doubles as the two-cycle drain counter.
        if (k_reg == KW'(1)) begin
          k_next     = '0;
          state_next = S_DONE;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign tap_addr = j_next[AW-1:0] + AW'(k_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      j_reg         <= '0;
      k_reg         <= '0;
      len_reg       <= '0;
      ksize_reg     <= '0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      w_raddr_reg   <= '0;
      mem_raddr_reg <= '0;
    end else begin
      state         <= state_next;
      j_reg         <= j_next;
      k_reg         <= k_next;
      len_reg       <= len_next;
      ksize_reg     <= ksize_next;
      err_reg       <= err_next;
      busy_reg      <= state_next inside {S_LOAD_W, S_RUN, S_DRAIN};
      done_reg      <= (state_next == S_DONE);
      w_raddr_reg   <= (state_next == S_LOAD_W) ? AW'(k_next) : '0;
      mem_raddr_reg <= (state_next == S_RUN) ? tap_addr : '0;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign w_raddr   = w_raddr_reg;
  assign mem_raddr = mem_raddr_reg;

  // Strobes below describe the read issued this cycle; delay lines align them with the returned data.
  logic            issue_run;
  logic [KMAX-1:0] w_ld_d;

  assign issue_run = (state == S_RUN);

  for (genvar gi = 0; gi < KMAX; gi++) begin : g_wld
    assign w_ld_d[gi] = (state == S_LOAD_W) && (k_reg == KW'(gi));
  end

  localparam int TAP_W = KMAX + 2 + KW;
  localparam int WR_W  = 1 + AW;

  logic [TAP_W-1:0] tap_d, tap_q;
  logic [WR_W-1:0]  wr_d, wr_q;

  assign tap_d = {w_ld_d, issue_run && (k_reg == '0), issue_run && (k_reg != '0),
                  issue_run ? k_reg : '0};
  assign wr_d  = {issue_run && k_last, issue_run ? j_reg[AW-1:0] : '0};

  ctrl_delay_line #(.WIDTH(TAP_W), .DEPTH(1)) u_tap_dly (
    .clk (clk),
    .rst (rst),
    .d   (tap_d),
    .q   (tap_q)
  );

  // The write follows the last tap's accumulate by one more cycle.
  ctrl_delay_line #(.WIDTH(WR_W), .DEPTH(2)) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .d   (wr_d),
    .q   (wr_q)
  );

  assign {w_ld, acc_clr, acc_en, k_idx} = tap_q;
  assign {out_we, out_waddr}            = wr_q;

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Scoreboard bench for conv1d_seq_ctrl: stimulus pushes expected strobes, a
// negedge monitor pops and compares them as the DUT raises each strobe.
module tb_conv1d_seq_ctrl;

  localparam int KMAX = 8;
  localparam int NMAX = 1024;
  localparam int AW   = 10;
  localparam int KW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [AW:0]     len = '0;
  logic [KW-1:0]   ksize = '0;
  logic            busy, done, err, acc_clr, acc_en, out_we;
  logic [AW-1:0]   w_raddr, mem_raddr, out_waddr;
  logic [KMAX-1:0] w_ld;
  logic [KW-1:0]   k_idx;

  conv1d_seq_ctrl #(.KMAX(KMAX), .NMAX(NMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .ksize     (ksize),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .w_raddr   (w_raddr),
    .w_ld      (w_ld),
    .mem_raddr (mem_raddr),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .k_idx     (k_idx),
    .out_we    (out_we),
    .out_waddr (out_waddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t q_wld[$];
  ev_t q_acc[$];
  ev_t q_we[$];
  ev_t q_done[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int bs = 1;
  int be = 0;
  logic [AW-1:0] prev_w_raddr = '0;
  logic [AW-1:0] prev_mem_raddr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    failures++;
    $display("FAIL %s: unexpected strobe value %0d with no expectation (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: registered read addresses from the previous cycle pair with this cycle's strobes.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (w_ld != '0) begin
        if (q_wld.size() == 0) unexpected("w_ld", int'(w_ld));
        else begin
          e = q_wld.pop_front();
          chk("w_ld_cycle", cyc, e.cyc);
          chk("w_ld", int'(w_ld), 1 << e.a);
          chk("w_raddr", int'(prev_w_raddr), e.a);
          $display("wld  cyc=%0d idx=%0d", cyc, e.a);
        end
      end
      if (acc_clr || acc_en) begin
        if (q_acc.size() == 0) unexpected("acc", int'({acc_clr, acc_en}));
        else begin
          e = q_acc.pop_front();
          chk("acc_cycle", cyc, e.cyc);
          chk("acc_clr", int'(acc_clr), int'(e.a == 0));
          chk("acc_en", int'(acc_en), int'(e.a != 0));
          chk("k_idx", int'(k_idx), e.a);
          chk("mem_raddr", int'(prev_mem_raddr), e.b);
        end
      end
      if (out_we) begin
        if (q_we.size() == 0) unexpected("out_we", int'(out_waddr));
        else begin
          e = q_we.pop_front();
          chk("out_we_cycle", cyc, e.cyc);
          chk("out_waddr", int'(out_waddr), e.a);
          $display("wr   cyc=%0d addr=%0d", cyc, out_waddr);
        end
      end
      if (done) begin
        if (q_done.size() == 0) unexpected("done", int'(err));
        else begin
          e = q_done.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_err", int'(err), e.a);
          $display("done cyc=%0d err=%0d", cyc, err);
        end
      end
      chk("busy", int'(busy), int'(cyc >= bs && cyc <= be));
    end
    prev_w_raddr   = w_raddr;
    prev_mem_raddr = mem_raddr;
  end

  task automatic run_cfg(input int l, input int ks, input bit interfere);
    int t0, m, dr;
    bit ok;
    ok = (ks >= 1) && (ks <= KMAX) && (ks <= l) && (l <= NMAX);
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    len   = (AW+1)'(l);
    ksize = KW'(ks);
    if (!ok) begin
      dr = 1;
      q_done.push_back('{cyc: t0 + 1, a: 1, b: 0});
      bs = 1;
      be = 0;
    end else begin
      m  = l - ks + 1;
      dr = (m + 1) * ks + 3;
      for (int i = 0; i < ks; i++) q_wld.push_back('{cyc: t0 + 2 + i, a: i, b: 0});
      for (int j = 0; j < m; j++) begin
        for (int k = 0; k < ks; k++)
          q_acc.push_back('{cyc: t0 + ks + 2 + j * ks + k, a: k, b: j + k});
        q_we.push_back('{cyc: t0 + (j + 2) * ks + 2, a: j, b: 0});
      end
      q_done.push_back('{cyc: t0 + dr, a: 0, b: 0});
      bs = t0 + 1;
      be = t0 + dr - 1;
    end
    $display("start cyc=%0d len=%0d ksize=%0d ok=%0d", t0, l, ks, ok);
    for (int c = 1; c <= dr + 1; c++) begin
      @(negedge clk);
      if (interfere && c < dr && (c % 5) == 2) begin
        start = 1'b1;
        len   = (AW+1)'(3);
        ksize = KW'(1);
      end else begin
        start = 1'b0;
        len   = interfere ? (AW+1)'(l + 3) : (AW+1)'(l);
        ksize = KW'(ks);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int t0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_w_ld", int'(w_ld), 0);
    chk("rst_out_we", int'(out_we), 0);
    chk("rst_mem_raddr", int'(mem_raddr), 0);
    @(negedge clk);
    rst = 1'b0;

    run_cfg(5, 3, 1'b0);
    run_cfg(1, 1, 1'b0);
    run_cfg(20, 0, 1'b0);
    chk("err_hold_k0", int'(err), 1);
    run_cfg(2, 3, 1'b0);
    chk("err_hold_len_lt_k", int'(err), 1);
    run_cfg(6, 2, 1'b0);
    chk("err_cleared", int'(err), 0);
    run_cfg(9, 9, 1'b0);
    run_cfg(1025, 4, 1'b0);
    run_cfg(7, 3, 1'b1);

    // Reset one cycle ahead of the first write of a len=5, ksize=3 run.
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    len   = (AW+1)'(5);
    ksize = KW'(3);
    for (int i = 0; i < 3; i++) q_wld.push_back('{cyc: t0 + 2 + i, a: i, b: 0});
    for (int k = 0; k < 3; k++) q_acc.push_back('{cyc: t0 + 5 + k, a: k, b: k});
    bs = t0 + 1;
    be = t0 + 7;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_acc", int'({acc_clr, acc_en}), 0);
    chk("mid_rst_k_idx", int'(k_idx), 0);
    chk("mid_rst_mem_raddr", int'(mem_raddr), 0);
    chk("mid_rst_w_raddr", int'(w_raddr), 0);
    chk("mid_rst_out_we", int'(out_we), 0);
    @(posedge clk);
    #1 chk("rst_hold_out_we", int'(out_we), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset cyc=%0d", cyc);

    run_cfg(5, 3, 1'b0);
    run_cfg(NMAX, KMAX, 1'b0);

    repeat (3) @(negedge clk);
    chk("left_wld", q_wld.size(), 0);
    chk("left_acc", q_acc.size(), 0);
    chk("left_we", q_we.size(), 0);
    chk("left_done", q_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
